// File: rtl/pow_n_sequential_if.sv
// rtl/pow_n_sequential_if.sv - request/result bundle for the sequential power unit
interface pow_n_sequential_if #(
    parameter int WIDTH = 18,
    parameter int EXP_W = 4
);
    logic             run;
    logic [WIDTH-1:0] n;
    logic [EXP_W-1:0] exp;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] n_pow;
    logic             overflow;

    modport master (
        output run, n, exp,
        input  busy, ready, n_pow, overflow
    );

    modport slave (
        input  run, n, exp,
        output busy, ready, n_pow, overflow
    );
endinterface

// File: rtl/pow_n_sequential.sv
// rtl/pow_n_sequential.sv - LSB-first square-and-multiply n**exp mod 2**WIDTH; POW_N_SEQUENTIAL_OVERFLOW_EN adds overflow tracking
module pow_n_sequential #(
    parameter int WIDTH = 18,
    parameter int EXP_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    pow_n_sequential_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_pow_q, n_pow_d;
    logic [WIDTH-1:0] sq_lo;
    logic [WIDTH-1:0] mul_lo;
    logic             accept;
    logic             last_bit;
    logic             busy;
    logic             ready;

    // A new request is taken only when no calculation is in flight.
    assign accept   = ((state_q == IDLE) || (state_q == DONE)) && bus.run;
    // The current exponent bit is the last one when nothing remains above it.
    assign last_bit = ((e_q >> 1) == '0);

`ifdef POW_N_SEQUENTIAL_OVERFLOW_EN
    logic [2*WIDTH-1:0] sq_full;
    logic [2*WIDTH-1:0] mul_full;

    assign sq_full  = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
    assign mul_full = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, base_q};
    assign sq_lo    = sq_full[WIDTH-1:0];
    assign mul_lo   = mul_full[WIDTH-1:0];
`else
    assign sq_lo    = base_q * base_q;
    assign mul_lo   = acc_q * base_q;
`endif

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: run is honoured in IDLE and DONE, ignored during CALC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.run) state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
            DONE:    state_d = bus.run ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state; busy and ready are exclusive by construction.
    always_comb begin
        busy  = (state_q == CALC);
        ready = (state_q == DONE);
    end

    assign bus.busy  = busy;
    assign bus.ready = ready;
    assign bus.n_pow = n_pow_q;

    // Datapath: load operands on accept, then one exponent bit per CALC cycle.
    always_comb begin
        base_d  = base_q;
        acc_d   = acc_q;
        e_d     = e_q;
        n_pow_d = n_pow_q;
        if (accept) begin
            base_d = bus.n;
            acc_d  = WIDTH'(1);
            e_d    = bus.exp;
        end else if (state_q == CALC) begin
            if (e_q[0]) begin
                acc_d = mul_lo;
            end
            base_d = sq_lo;
            e_d    = e_q >> 1;
            if (last_bit) begin
                n_pow_d = acc_d;
            end
        end
    end

    // Working registers need no reset: they are always reloaded before use.
    always_ff @(posedge clock) begin
        base_q <= base_d;
        acc_q  <= acc_d;
        e_q    <= e_d;
    end

    // Result register changes only on entry to DONE or on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_pow_q <= '0;
        end else begin
            n_pow_q <= n_pow_d;
        end
    end

`ifdef POW_N_SEQUENTIAL_OVERFLOW_EN
    logic base_ovf_q, base_ovf_d;
    logic res_ovf_q, res_ovf_d;
    logic overflow_q, overflow_d;

    // Sticky truncation tracking; a truncated base poisons every later multiply that uses it.
    always_comb begin
        base_ovf_d = base_ovf_q;
        res_ovf_d  = res_ovf_q;
        overflow_d = overflow_q;
        if (accept) begin
            base_ovf_d = 1'b0;
            res_ovf_d  = 1'b0;
        end else if (state_q == CALC) begin
            if (e_q[0] && ((|mul_full[2*WIDTH-1:WIDTH]) || base_ovf_q)) begin
                res_ovf_d = 1'b1;
            end
            // The squared base from the final cycle is never consumed, so it cannot overflow the result.
            if (!last_bit && (|sq_full[2*WIDTH-1:WIDTH])) begin
                base_ovf_d = 1'b1;
            end
            if (last_bit) begin
                overflow_d = res_ovf_d;
            end
        end
    end

    // Overflow flags; the published flag is held alongside n_pow.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_ovf_q <= 1'b0;
            res_ovf_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            base_ovf_q <= base_ovf_d;
            res_ovf_q  <= res_ovf_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

endmodule
